ls_ptltx_sync: RTL

//  Clocked transmit-side model for a passive transmission line (PTL) link.

---
 rtl/ls_ptltx_sync_if.sv | 24 ++
 rtl/ls_ptltx_sync.sv | 103 ++++++++++
 2 files changed

// File: rtl/ls_ptltx_sync_if.sv
// Pulse-source side of the PTL transmit block: toggle-encoded request in,
// toggle-encoded line drive plus status and traffic counters out.
`timescale 1ns/1ps

interface ls_ptltx_sync_if #(
    parameter int CNT_W = 16
);
    logic             a;
    logic             q;
    logic             q_valid;
    logic             err;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output a,
        input  q, q_valid, err, pulse_cnt, viol_cnt
    );

    modport slave (
        input  a,
        output q, q_valid, err, pulse_cnt, viol_cnt
    );
endinterface

// File: rtl/ls_ptltx_sync.sv
// Clocked PTL transmit model: forwards toggle-encoded pulses after a fixed delay,
// enforces the critical-time spacing, latches violations and counts traffic.
`timescale 1ns/1ps

module ls_ptltx_sync #(
    parameter int DELAY_CYC   = 6,
    parameter int CT_CYC      = 7,
    parameter int STARTUP_CYC = 5,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    ls_ptltx_sync_if.slave     bus
);
    localparam int HO_W = (CT_CYC < 2)      ? 1 : $clog2(CT_CYC);
    localparam int ST_W = (STARTUP_CYC < 1) ? 1 : $clog2(STARTUP_CYC + 1);

    logic                 a_prev;
    logic [ST_W-1:0]      startup_cnt;
    logic [HO_W-1:0]      holdoff;
    logic [DELAY_CYC-1:0] dline;
    logic [DELAY_CYC-1:0] dline_next;
    logic                 q_r;
    logic                 q_valid_r;
    logic                 err_r;
    logic [CNT_W-1:0]     pulse_cnt_r;
    logic [CNT_W-1:0]     viol_cnt_r;

    logic event_seen;
    logic started;
    logic violation;
    logic accept;

    always_comb begin
        event_seen = (bus.a != a_prev);
        started    = (startup_cnt >= ST_W'(STARTUP_CYC));
        // A holdoff of 1 at the event edge is still inside the critical time.
        violation  = event_seen && started && (holdoff != '0);
        accept     = event_seen && started && (holdoff == '0) && !err_r;
    end

    always_comb begin
        dline_next    = '0;
        dline_next[0] = accept;
        for (int i = 1; i < DELAY_CYC; i++) begin
            dline_next[i] = dline[i-1];
        end
    end

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // blocking assignments would let the shift line collapse in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_prev      <= bus.a;
            startup_cnt <= '0;
            holdoff     <= '0;
            // NOTE: the delay line is a handful of flops, not a RAM, so it is
            // reset; that is what discards in-flight pulses on a mid-run reset.
            dline       <= '0;
            q_r         <= 1'b0;
            q_valid_r   <= 1'b1;
            err_r       <= 1'b0;
            pulse_cnt_r <= '0;
            viol_cnt_r  <= '0;
        end else begin
            a_prev <= bus.a;

            if (!started) begin
                startup_cnt <= startup_cnt + ST_W'(1);
            end

            if (accept) begin
                holdoff <= HO_W'(CT_CYC - 1);
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HO_W'(1);
            end

            // A violation cancels everything in flight, including a pulse
            // that would have left the line on this same edge.
            if (violation) begin
                err_r     <= 1'b1;
                q_valid_r <= 1'b0;
                dline     <= '0;
                if (viol_cnt_r != '1) begin
                    viol_cnt_r <= viol_cnt_r + CNT_W'(1);
                end
            end else begin
                dline <= dline_next;
                if (dline[DELAY_CYC-1]) begin
                    q_r         <= ~q_r;
                    pulse_cnt_r <= pulse_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign bus.q         = q_r;
    assign bus.q_valid   = q_valid_r;
    assign bus.err       = err_r;
    assign bus.pulse_cnt = pulse_cnt_r;
    assign bus.viol_cnt  = viol_cnt_r;

endmodule
